// File: rtl/sfp_frame_pkg.sv
// sfp_frame_pkg: shared constants, FSM state type and beat-count helper
// for the SFP telemetry framer.
package sfp_frame_pkg;

  localparam logic [7:0]  SFP_SYNC      = 8'hA5;
  localparam logic [31:0] SFP_TRL_MAGIC = 32'h5A5A5A5A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    TRL  = 2'd3
  } state_e;

  // Two 32-bit channels per payload beat, rounded up.
  function automatic int nb_beats(input int num_ch);
    return (num_ch + 1) / 2;
  endfunction

endpackage

// File: rtl/sfp_tick_gen.sv
// sfp_tick_gen: free-running period counter that emits a one-cycle tick
// every PERIOD_CYC enabled cycles. PERIOD_CYC=0 ties the tick low.
module sfp_tick_gen #(
  parameter int PERIOD_CYC = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  if (PERIOD_CYC == 0) begin : g_off
    logic unused_tick_inputs;
    assign unused_tick_inputs = ^{i_clk, i_rst, i_en};
    assign o_tick = 1'b0;
  end else begin : g_cnt
    localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Advance while enabled, wrapping to zero on the cycle that ticks.
    always_comb begin
      cnt_d = cnt_q;
      if (i_en) begin
        if (cnt_q == LAST) cnt_d = '0;
        else               cnt_d = cnt_q + CW'(1);
      end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign o_tick = i_en && (cnt_q == LAST);
  end

endmodule

// File: rtl/sfp_telemetry_framer.sv
// sfp_telemetry_framer: snapshots NUM_CH 32-bit telemetry channels on a
// trigger and sends them as one AXI4-Stream frame (header, payload,
// checksum trailer) toward the SFP TX FIFO.
// Optional statistics ports (o_drop_cnt, o_frame_cnt) are built only when
// the macro SFP_FRAMER_STATS_EN is defined.
module sfp_telemetry_framer
  import sfp_frame_pkg::*;
#(
  parameter int NUM_CH     = 9,
  parameter int PERIOD_CYC = 0,
  parameter int SEQ_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_trig,
  input  logic [1:0]            i_sfp_id,
  input  logic [NUM_CH*32-1:0]  i_ch_data,
  output logic [63:0]           o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic [SEQ_W-1:0]      o_seq
`ifdef SFP_FRAMER_STATS_EN
  ,
  output logic [15:0]           o_drop_cnt,
  output logic [31:0]           o_frame_cnt
`endif
);

  localparam int NB  = nb_beats(NUM_CH);
  localparam int CHW = NUM_CH * 32;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [7:0]         beat_q, beat_d;
  logic [CHW-1:0]     snap_q, snap_d;
  logic [1:0]         id_q, id_d;
  logic [SEQ_W-1:0]   sseq_q, sseq_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;

  logic               tick;
  logic               trig;
  logic               accept;
  logic               drop_evt;
  logic               trl_done;

  logic [63:0]        hdr_w;
  logic [63:0]        pay_w;
  logic [31:0]        csum_w;
  logic [NB*64-1:0]   pad_w;

  sfp_tick_gen #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .o_tick (tick)
  );

  assign trig     = (i_trig | tick) & i_en;
  assign accept   = o_tvalid & i_tready;
  assign drop_evt = (state_q != IDLE) && trig && pend_q;
  assign trl_done = (state_q == TRL) && accept;

  // Frame sequencing, snapshot capture and the one-deep pending request.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    beat_d  = beat_q;
    snap_d  = snap_q;
    id_d    = id_q;
    sseq_d  = sseq_q;
    seq_d   = seq_q;
    case (state_q)
      IDLE: begin
        if (!i_en) begin
          pend_d = 1'b0;
        end else if (trig || pend_q) begin
          snap_d  = i_ch_data;
          id_d    = i_sfp_id;
          sseq_d  = seq_q;
          pend_d  = 1'b0;
          beat_d  = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (accept) state_d = PAY;
      end
      PAY: begin
        if (accept) begin
          if (beat_q == 8'(NB - 1)) state_d = TRL;
          else                      beat_d  = beat_q + 8'd1;
        end
      end
      TRL: begin
        if (accept) begin
          seq_d   = seq_q + SEQ_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      if (!i_en)     pend_d = 1'b0;
      else if (trig) pend_d = 1'b1;
    end
  end

  // Beat contents are derived from the frozen snapshot only.
  always_comb begin
    hdr_w              = '0;
    hdr_w[63:56]       = SFP_SYNC;
    hdr_w[55:48]       = 8'(NUM_CH);
    hdr_w[47:46]       = id_q;
    hdr_w[SEQ_W-1:0]   = sseq_q;
    pad_w              = '0;
    pad_w[CHW-1:0]     = snap_q;
    pay_w              = '0;
    for (int k = 0; k < NB; k++) begin
      if (beat_q == 8'(k)) begin
        pay_w[63:32] = pad_w[64*k +: 32];
        pay_w[31:0]  = pad_w[64*k+32 +: 32];
      end
    end
    csum_w = hdr_w[63:32] ^ hdr_w[31:0];
    for (int k = 0; k < NUM_CH; k++) begin
      csum_w = csum_w ^ snap_q[32*k +: 32];
    end
  end

  // Select the beat presented on the stream for the current state.
  always_comb begin
    o_tdata = '0;
    case (state_q)
      HDR:     o_tdata = hdr_w;
      PAY:     o_tdata = pay_w;
      TRL:     o_tdata = {SFP_TRL_MAGIC, csum_w};
      default: o_tdata = '0;
    endcase
  end

  assign o_tvalid = (state_q != IDLE);
  assign o_tlast  = (state_q == TRL);
  assign o_busy   = (state_q != IDLE);
  assign o_seq    = seq_q;

  // Framer state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      beat_q  <= '0;
      snap_q  <= '0;
      id_q    <= '0;
      sseq_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
      snap_q  <= snap_d;
      id_q    <= id_d;
      sseq_q  <= sseq_d;
      seq_q   <= seq_d;
    end
  end

`ifdef SFP_FRAMER_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [31:0] fcnt_q, fcnt_d;

  // Saturating dropped-trigger count and wrapping completed-frame count.
  always_comb begin
    drop_d = drop_q;
    fcnt_d = fcnt_q;
    if (drop_evt && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if (trl_done)                         fcnt_d = fcnt_q + 32'd1;
  end

  // Statistics registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_q <= '0;
      fcnt_q <= '0;
    end else begin
      drop_q <= drop_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign o_drop_cnt  = drop_q;
  assign o_frame_cnt = fcnt_q;
`else
  logic unused_stats;
  assign unused_stats = drop_evt ^ trl_done;
`endif

endmodule

// File: tb/tb_sfp_telemetry_framer.sv
// tb_sfp_telemetry_framer: directed self-checking bench for the SFP
// telemetry framer. Main instance: NUM_CH=3, external trigger, SEQ_W=4.
// Second instance: NUM_CH=2 with PERIOD_CYC=100 for the internal tick.
// Statistics checks are compiled in when SFP_FRAMER_STATS_EN is defined.
module tb_sfp_telemetry_framer;

  localparam logic [95:0] CH_STD = {32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [95:0] CH_BAD = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_trig;
  logic        i_tready;
  logic [1:0]  i_sfp_id;
  logic [95:0] i_ch_data;
  logic [63:0] o_tdata;
  logic        o_tvalid;
  logic        o_tlast;
  logic        o_busy;
  logic [3:0]  o_seq;

  logic        en2;
  logic        trig2;
  logic        tready2;
  logic [1:0]  id2;
  logic [63:0] ch2;
  logic [63:0] tdata2;
  logic        tvalid2;
  logic        tlast2;
  logic        busy2;
  logic [31:0] seq2;

`ifdef SFP_FRAMER_STATS_EN
  logic [15:0] drop_cnt;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt2;
  logic [31:0] frame_cnt2;
`endif

  int nAsserts = 0;
  int nFails   = 0;
  int frames2  = 0;

  always #5 clk = ~clk;

  sfp_telemetry_framer #(
    .NUM_CH     (3),
    .PERIOD_CYC (0),
    .SEQ_W      (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_trig      (i_trig),
    .i_sfp_id    (i_sfp_id),
    .i_ch_data   (i_ch_data),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .i_tready    (i_tready),
    .o_tlast     (o_tlast),
    .o_busy      (o_busy),
    .o_seq       (o_seq)
`ifdef SFP_FRAMER_STATS_EN
    ,
    .o_drop_cnt  (drop_cnt),
    .o_frame_cnt (frame_cnt)
`endif
  );

  sfp_telemetry_framer #(
    .NUM_CH     (2),
    .PERIOD_CYC (100),
    .SEQ_W      (32)
  ) dut_tick (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (en2),
    .i_trig      (trig2),
    .i_sfp_id    (id2),
    .i_ch_data   (ch2),
    .o_tdata     (tdata2),
    .o_tvalid    (tvalid2),
    .i_tready    (tready2),
    .o_tlast     (tlast2),
    .o_busy      (busy2),
    .o_seq       (seq2)
`ifdef SFP_FRAMER_STATS_EN
    ,
    .o_drop_cnt  (drop_cnt2),
    .o_frame_cnt (frame_cnt2)
`endif
  );

  // Count accepted trailers of the periodic instance away from the active edge.
  always @(negedge clk) begin
    if (tvalid2 && tready2 && tlast2) frames2++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic trig, input logic en, input logic tready);
    i_trig   = trig;
    i_en     = en;
    i_tready = tready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expBeat(input int b, input logic [3:0] s);
    logic [63:0] r;
    case (b)
      0:       r = {32'hA5038000, 28'h0, s};
      1:       r = 64'h11111111_22222222;
      2:       r = 64'h33333333_00000000;
      default: r = {32'h5A5A5A5A, 32'hA5038000 ^ {28'h0, s}};
    endcase
    return r;
  endfunction

  task automatic collectFrame(input string tag, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      i_tready = 1'b1;
      for (int w = 0; w < 20 && o_tvalid !== 1'b1; w++) step();
      checkOutput($sformatf("%s valid%0d", tag, b), {63'h0, o_tvalid}, 64'd1);
      checkOutput($sformatf("%s beat%0d", tag, b), o_tdata, expBeat(b, s));
      checkOutput($sformatf("%s last%0d", tag, b), {63'h0, o_tlast}, {63'h0, (b == 3)});
      step();
    end
  endtask

  // Watchdog so a stuck design still terminates the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    i_rst     = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    i_sfp_id  = 2'd2;
    i_ch_data = CH_STD;
    en2       = 1'b0;
    trig2     = 1'b0;
    tready2   = 1'b1;
    id2       = 2'd0;
    ch2       = 64'h0;
    repeat (3) step();

    $display("[TB] reset state");
    checkOutput("rst tvalid", {63'h0, o_tvalid}, 64'd0);
    checkOutput("rst tdata", o_tdata, 64'd0);
    checkOutput("rst tlast", {63'h0, o_tlast}, 64'd0);
    checkOutput("rst busy", {63'h0, o_busy}, 64'd0);
    checkOutput("rst seq", {60'h0, o_seq}, 64'd0);
    checkOutput("rst busy2", {63'h0, busy2}, 64'd0);
`ifdef SFP_FRAMER_STATS_EN
    checkOutput("rst drop", {48'h0, drop_cnt}, 64'd0);
    checkOutput("rst fcnt", {32'h0, frame_cnt}, 64'd0);
`endif
    i_rst = 1'b0;
    step();

    $display("[TB] test 1: basic frame with snapshot immunity");
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    i_trig    = 1'b0;
    i_ch_data = CH_BAD;
    collectFrame("t1", 4'd0);
    checkOutput("t1 seq", {60'h0, o_seq}, 64'd1);
    checkOutput("t1 idle", {63'h0, o_tvalid}, 64'd0);

    $display("[TB] test 2: stalled frame");
    i_ch_data = CH_STD;
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    i_trig = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_tready = 1'b0;
      checkOutput($sformatf("t2 pre%0d", b), o_tdata, expBeat(b, 4'd1));
      step();
      checkOutput($sformatf("t2 hold%0d", b), o_tdata, expBeat(b, 4'd1));
      checkOutput($sformatf("t2 vhold%0d", b), {63'h0, o_tvalid}, 64'd1);
      i_tready = 1'b1;
      step();
    end
    checkOutput("t2 idle", {63'h0, o_tvalid}, 64'd0);
    checkOutput("t2 seq", {60'h0, o_seq}, 64'd2);

    $display("[TB] test 3: three triggers during one frame");
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    i_trig = 1'b0;
    step();
    i_trig = 1'b1;
    step();
    i_trig = 1'b0;
    step();
    i_trig = 1'b1;
    step();
    i_trig = 1'b0;
    checkOutput("t3 busy", {63'h0, o_busy}, 64'd1);
    collectFrame("t3a", 4'd2);
    checkOutput("t3 bubble", {63'h0, o_tvalid}, 64'd0);
    collectFrame("t3b", 4'd3);
    repeat (10) step();
    checkOutput("t3 no third", {63'h0, o_tvalid}, 64'd0);
    checkOutput("t3 seq", {60'h0, o_seq}, 64'd4);
`ifdef SFP_FRAMER_STATS_EN
    checkOutput("t3 drop", {48'h0, drop_cnt}, 64'd1);
    checkOutput("t3 fcnt", {32'h0, frame_cnt}, 64'd4);
`endif

    $display("[TB] trigger with enable low");
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    i_trig = 1'b0;
    step();
    checkOutput("en0 ignore", {63'h0, o_tvalid}, 64'd0);
    i_en = 1'b1;

    $display("[TB] test 4: internal period tick");
    en2 = 1'b1;
    repeat (1000) step();
    checkOutput("t4 frames9", 64'(frames2), 64'd9);
    checkOutput("t4 busy", {63'h0, busy2}, 64'd1);
    en2 = 1'b0;
    repeat (10) step();
    checkOutput("t4 busy done", {63'h0, busy2}, 64'd0);
    checkOutput("t4 frames10", 64'(frames2), 64'd10);
    checkOutput("t4 seq", {32'h0, seq2}, 64'd10);
    repeat (300) step();
    checkOutput("t4 no more", 64'(frames2), 64'd10);
    checkOutput("t4 valid off", {63'h0, tvalid2}, 64'd0);

    $display("[TB] test 5: reset mid-payload");
    i_ch_data = CH_STD;
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    i_trig = 1'b0;
    step();
    step();
    checkOutput("t5 pay1", o_tdata, 64'h33333333_00000000);
    i_rst = 1'b1;
    step();
    checkOutput("t5 tvalid", {63'h0, o_tvalid}, 64'd0);
    checkOutput("t5 seq", {60'h0, o_seq}, 64'd0);
    checkOutput("t5 busy", {63'h0, o_busy}, 64'd0);
`ifdef SFP_FRAMER_STATS_EN
    checkOutput("t5 drop", {48'h0, drop_cnt}, 64'd0);
`endif
    i_rst = 1'b0;
    step();

    $display("[TB] test 6: sequence wrap over 17 frames");
    for (int f = 0; f < 17; f++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      step();
      i_trig = 1'b0;
      collectFrame($sformatf("t6 f%0d", f), 4'(f));
    end
    checkOutput("t6 seq", {60'h0, o_seq}, 64'd1);
`ifdef SFP_FRAMER_STATS_EN
    checkOutput("t6 fcnt", {32'h0, frame_cnt}, 64'd17);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
